// File: rtl/program_loader.sv
// program_loader: byte-stream loader writing DEPTH instruction words into CPU RAM, then releasing the CPU once the XOR checksum matches.
module program_loader #(
  parameter int DATA_W = 11,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] RAM_Write_Data,
  output logic [ADDR_W-1:0] RAM_Write_Address,
  output logic              RAM_Write_Enable,
  output logic              PC_Enable,
  output logic              busy,
  output logic              done,
  output logic              error
);
  typedef enum logic [2:0] {IDLE, LO, HI, WR, CSUM, RUN, ERR} state_t;
  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        csum;
  logic [7:0]        lo;
  logic              xfer;
  logic              hi_bad;
  logic              last;
  always_comb begin
    in_ready         = state inside {LO, HI, CSUM};
    busy             = state inside {LO, HI, WR, CSUM};
    RAM_Write_Enable = state == WR;
    PC_Enable        = state == RUN;
    done             = state == RUN;
    error            = state == ERR;
    xfer             = in_valid && in_ready;
    hi_bad           = |(in_byte >> (DATA_W - 8));
    last             = addr == ADDR_W'(DEPTH - 1);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      addr              <= '0;
      csum              <= '0;
      lo                <= '0;
      RAM_Write_Data    <= '0;
      RAM_Write_Address <= '0;
    end else begin
      case (state)
        IDLE, RUN, ERR: if (start) begin
          state <= LO;
          addr  <= '0;
          csum  <= '0;
        end
        LO: if (xfer) begin
          lo    <= in_byte;
          csum  <= csum ^ in_byte;
          state <= HI;
        end
        // unused high bits set means a malformed stream; nothing is written
        HI: if (xfer) begin
          if (hi_bad) state <= ERR;
          else begin
            RAM_Write_Data    <= DATA_W'({in_byte, lo});
            RAM_Write_Address <= addr;
            csum              <= csum ^ in_byte;
            state             <= WR;
          end
        end
        WR: begin
          state <= last ? CSUM : LO;
          addr  <= last ? addr : addr + 1'b1;
        end
        CSUM: if (xfer) state <= (in_byte == csum) ? RUN : ERR;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: scoreboard bench for program_loader; expected RAM writes are queued as bytes are sent and popped on each write strobe.
module tb_program_loader;
  logic        clk = 0;
  logic        reset = 1;
  logic        start = 0;
  logic [7:0]  in_byte = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [10:0] RAM_Write_Data;
  logic [2:0]  RAM_Write_Address;
  logic        RAM_Write_Enable, PC_Enable, busy, done, error;
  int          checks = 0;
  int          errors = 0;
  int          we_count = 0;
  logic [13:0] sb[$];
  logic [13:0] exp_w;
  logic [10:0] prog[8];

  program_loader dut (
    .clk(clk), .reset(reset), .start(start), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready), .RAM_Write_Data(RAM_Write_Data), .RAM_Write_Address(RAM_Write_Address),
    .RAM_Write_Enable(RAM_Write_Enable), .PC_Enable(PC_Enable), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (RAM_Write_Enable) begin
    we_count++;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL wr_unexpected got addr=%0d data=%h, expected no write", RAM_Write_Address, RAM_Write_Data);
    end else begin
      exp_w = sb.pop_front();
      if ({RAM_Write_Address, RAM_Write_Data} !== exp_w) begin
        errors++;
        $display("FAIL wr_data got addr=%0d data=%h, expected addr=%0d data=%h",
                 RAM_Write_Address, RAM_Write_Data, exp_w[13:11], exp_w[10:0]);
      end
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL wr_ready got %b expected 0", in_ready);
    end
  end

  function automatic logic [7:0] prog_csum();
    logic [7:0] c = 0;
    for (int i = 0; i < 8; i++) c ^= prog[i][7:0] ^ {5'b0, prog[i][10:8]};
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, want);
    end
  endtask

  task automatic start_pulse();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got in_ready=0 expected 1 within 50 cycles");
    end
    in_byte  = b;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic load_words(input int from, input int upto, input int gap);
    for (int i = from; i < upto; i++) begin
      sb.push_back({3'(i), prog[i]});
      send_byte(prog[i][7:0], gap);
      send_byte({5'b0, prog[i][10:8]}, gap);
    end
  endtask

  task automatic check_run(input string name);
    check({name, "_pc"}, PC_Enable, 1);
    check({name, "_done"}, done, 1);
    check({name, "_err"}, error, 0);
    check({name, "_sb"}, sb.size(), 0);
  endtask

  task automatic test_reset();
    check("rst_outs", {in_ready, RAM_Write_Enable, PC_Enable, busy, done, error}, 0);
    check("rst_ram", {RAM_Write_Address, RAM_Write_Data}, 0);
  endtask

  task automatic test_nominal();
    start_pulse();
    check("nom_busy", busy, 1);
    load_words(0, 3, 0);
    @(negedge clk);
    start_pulse();
    load_words(3, 8, 0);
    send_byte(prog_csum(), 0);
    check_run("nom");
    check("nom_wcount", we_count, 8);
  endtask

  task automatic test_bad_csum();
    start_pulse();
    load_words(0, 8, 0);
    send_byte(prog_csum() ^ 8'h01, 0);
    check("bad_err", error, 1);
    check("bad_pc", PC_Enable, 0);
    check("bad_done", done, 0);
    check("bad_sb", sb.size(), 0);
  endtask

  task automatic test_illegal_hi();
    int c;
    start_pulse();
    check("ill_errclr", error, 0);
    c = we_count;
    send_byte(8'h00, 0);
    send_byte(8'h08, 0);
    check("ill_err", error, 1);
    check("ill_pc", PC_Enable, 0);
    repeat (3) @(negedge clk);
    check("ill_nowrite", we_count, c);
  endtask

  task automatic test_recover();
    start_pulse();
    check("rec_errclr", error, 0);
    load_words(0, 8, 0);
    send_byte(prog_csum(), 0);
    check_run("rec");
  endtask

  task automatic test_backpressure();
    start_pulse();
    load_words(0, 8, 2);
    send_byte(prog_csum(), 2);
    check_run("bp");
  endtask

  task automatic test_reset_midload();
    start_pulse();
    load_words(0, 4, 0);
    @(negedge clk);
    #2 reset = 1;
    #1;
    check("mid_outs", {in_ready, RAM_Write_Enable, PC_Enable, busy, done, error}, 0);
    check("mid_ram", {RAM_Write_Address, RAM_Write_Data}, 0);
    #1 reset = 0;
    @(negedge clk);
    check("mid_idle", busy, 0);
    start_pulse();
    check("mid_start", busy, 1);
    load_words(0, 8, 0);
    send_byte(prog_csum(), 0);
    check_run("mid");
  endtask

  task automatic test_back_to_back();
    start_pulse();
    check("rel_pc", PC_Enable, 0);
    check("rel_busy", busy, 1);
    for (int i = 0; i < 8; i++) prog[i] = prog[i] ^ 11'h7FF;
    load_words(0, 8, 0);
    send_byte(prog_csum(), 0);
    check_run("rel");
  endtask

  initial begin
    prog = '{11'h7FF, 11'h001, 11'h400, 11'h2AA, 11'h155, 11'h000, 11'h123, 11'h456};
    #1;
    test_reset();
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    test_nominal();
    test_bad_csum();
    test_illegal_hi();
    test_recover();
    test_backpressure();
    test_reset_midload();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Byte-stream program loader that drives the 5-bit CPU's external RAM write port: RAM_Write_Data, RAM_Write_Address, RAM_Write_Enable, and PC_Enable.
- Receives DEPTH 11-bit instructions as byte pairs over a valid/ready handshake, followed by an XOR checksum byte.
- Writes each instruction into CPU RAM one at a time.
- Releases the CPU (PC_Enable=1) only after a fully verified load. PC_Enable stays 0 throughout loading and after any error.

Parameters:
- DATA_W, 11, instruction width; must be ≤16.
- ADDR_W, 3, RAM address width.
- DEPTH, 8, number of instructions per load; must be ≤2^ADDR_W.

Ports:
- clk  input  1  system clock, same clock as the CPU RAM.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a new load.
- in_byte  input  8  incoming program byte.
- in_valid  input  1  in_byte is valid.
- in_ready  output  1  loader accepts in_byte this cycle.
- RAM_Write_Data  output  DATA_W  instruction word to CPU RAM.
- RAM_Write_Address  output  ADDR_W  target RAM row.
- RAM_Write_Enable  output  1  one-cycle write strobe.
- PC_Enable  output  1  CPU run enable.
- busy  output  1  load in progress (states LO, HI, WR, CSUM).
- done  output  1  load verified; CPU running.
- error  output  1  load failed.

Behaviour:
- Reset (async, active-high): state=IDLE. All outputs 0: in_ready=0, RAM_Write_*=0, PC_Enable=0, busy=0, done=0, error=0. Internal addr=0, csum=0.
- Transfer rule: a byte transfers on a rising edge where in_valid && in_ready. in_ready is a combinational function of state only (1 in LO, HI, CSUM; otherwise 0). It never depends on in_valid.
- Byte order per word: low byte first = data[7:0]. High byte second: bits [DATA_W-9:0] = data[DATA_W-1:8]; the remaining upper bits must be 0.
- States and transitions:
  - IDLE: start → LO; addr←0, csum←0.
  - LO: on transfer, lo←in_byte, csum←csum^in_byte → HI.
  - HI: on transfer, if unused high bits ≠0 → ERR. Otherwise register RAM_Write_Data←{hi bits, lo}, RAM_Write_Address←addr, csum←csum^in_byte → WR.
  - WR: RAM_Write_Enable=1 for exactly this one cycle. If addr==DEPTH-1 → CSUM; else addr←addr+1 → LO.
  - CSUM: on transfer, if in_byte==csum → RUN, else → ERR.
  - RUN: PC_Enable=1, done=1. start → LO, with PC_Enable=0 and done=0 from the next cycle; addr and csum cleared.
  - ERR: error=1, PC_Enable=0. start → LO, with error cleared and addr and csum cleared.
- start is ignored in LO, HI, WR, and CSUM. A load cannot be restarted mid-stream except by reset.
- Latency: the write strobe occurs 1 cycle after the high-byte transfer. A full load takes at least 3·DEPTH+1 cycles plus handshake stalls. For DEPTH=8 that is 25 cycles minimum.
- Output timing: RAM_Write_Data and RAM_Write_Address hold their last values outside WR. RAM_Write_Enable is 0 in every state except WR.
- PC_Enable is registered and asserts 1 cycle after the checksum transfer.
- Address wrap: addr never exceeds DEPTH-1; the final word goes to row DEPTH-1.
- Reset mid-load: returns to IDLE immediately. RAM rows already written are left as written. The CPU stays halted.
- in_valid held high with in_ready=0 (in WR): no byte is consumed, and the byte is taken in the next LO cycle.
- Checksum: 8-bit XOR of all 2·DEPTH program bytes.

Test Plan:
- Nominal load: after reset, start. Send words 0x7FF,0x001,0x400,0x2AA,0x155,0x000,0x123,0x456 as lo/hi byte pairs, then csum. → 8 single-cycle RAM_Write_Enable pulses at addresses 0..7 with those data values. PC_Enable=1 and done=1 one cycle after csum; error=0.
- Bad checksum: same stream with csum^0x01. → all 8 writes occur, then error=1, PC_Enable stays 0, done=0.
- Illegal high byte: first word low=0x00, high=0x08. → ERR on that transfer, with no RAM_Write_Enable pulse ever.
- Then start plus a valid stream → error clears and the load completes normally.
- Backpressure/stall: in_valid toggles 1 cycle on, 2 off. → writes and PC_Enable match the nominal case. in_ready=0 in every WR cycle.
- Reset mid-load: assert reset after word 3's write. → all outputs 0 asynchronously, state IDLE. start is ignored only while busy. A subsequent full load succeeds.
- Reload from RUN: in RUN, pulse start. → PC_Enable drops the next cycle and busy=1. A new 8-word load rewrites addresses 0..7 and re-enables the CPU.
